// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR round-robin scheduler.
// The x^16+x^14+x^13+x^11+1 Fibonacci taps are fixed here.
package lfsr_pkg;
  localparam int LFSR_W = 16;
  localparam int ID_W   = 3;
  localparam int TAP0   = 15;
  localparam int TAP1   = 13;
  localparam int TAP2   = 12;
  localparam int TAP3   = 10;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_STEP, S_RESP} state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]};
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// 16-bit Fibonacci LFSR register with load/step/hold control.
// Load takes precedence over step; otherwise the state holds.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (load)      s_d = load_val;
    else if (step) s_d = lfsr_next(s_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_q <= SEED;
    else          s_q <= s_d;
  end

  assign state = s_q;
endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler handing out one fresh LFSR word per grant; seed loads only when idle.
// Define LFSR_STAT_EN to add the saturating step_cnt counter and its stat_clr input.
module lfsr_rr_sched
  import lfsr_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter int                WIDTH   = LFSR_W,
  parameter logic [WIDTH-1:0]  SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic               seed_valid,
  input  logic [WIDTH-1:0]   seed_data,
  output logic               seed_ack,
  output logic [WIDTH-1:0]   y
`ifdef LFSR_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        step_cnt
`endif
);
  state_e              state_q;
  logic [ID_W-1:0]     gnt_id_q, rr_ptr_q, rsp_id_q;
  logic                rsp_valid_q;
  logic [WIDTH-1:0]    rsp_data_q;
  logic [WIDTH-1:0]    lfsr_q, seed_val;
  logic [ID_W-1:0]     arb_id;
  logic                arb_hit;

  // A zero seed would lock the LFSR at zero forever, so substitute the reset seed.
  assign seed_val = (seed_data == '0) ? SEED : seed_data;

  lfsr_core #(.SEED(SEED)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (state_q == S_STEP),
    .load     (state_q == S_SEED),
    .load_val (seed_val),
    .state    (lfsr_q)
  );

  always_comb begin
    arb_id  = '0;
    arb_hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!arb_hit && req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (seed_valid) begin
            state_q <= S_SEED;
          end else if (arb_hit) begin
            gnt_id_q <= arb_id;
            state_q  <= S_STEP;
          end
        end
        S_SEED: state_q <= S_IDLE;
        S_STEP: begin
          rsp_data_q  <= lfsr_next(lfsr_q);
          rsp_id_q    <= gnt_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= gnt_id_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ack lands in the handshake cycle so the requester can drop req before the next arbitration.
  assign ack       = (rsp_valid_q && rsp_ready) ? (NUM_REQ'(1) << rsp_id_q) : '0;
  assign seed_ack  = (state_q == S_SEED);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign y         = lfsr_q;

`ifdef LFSR_STAT_EN
  logic [31:0] step_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      step_cnt_q <= '0;
    else if (stat_clr)                                 step_cnt_q <= '0;
    else if (state_q == S_STEP && step_cnt_q != '1)    step_cnt_q <= step_cnt_q + 32'd1;
  end

  assign step_cnt = step_cnt_q;
`endif
endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Bench for lfsr_rr_sched: directed steps plus randomized transactions against a behavioural model.
module tb_lfsr_rr_sched;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        seed_ack;
  logic [15:0] y;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: current LFSR word and last granted requester.
  logic [15:0] m_lfsr;
  int          m_ptr;

  lfsr_rr_sched #(.NUM_REQ(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ack(seed_ack), .y(y)
  );

  always #5 clk = ~clk;

  // Feedback is the parity of the tapped bits 15,13,12,10 (mask 0xB400).
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] m;
    m = s & 16'hB400;
    return {s[14:0], ^m};
  endfunction

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant/response transaction; DUT must be idle on entry.
  task automatic do_txn(input logic [3:0] reqv, input int dly, input bit hold);
    int          id;
    logic [15:0] exp;
    logic [3:0]  oh;
    id  = pick(reqv, m_ptr);
    exp = model_step(m_lfsr);
    oh  = 4'b0001 << id;
    req = reqv;
    tick();
    chk("step_no_valid", 32'(rsp_valid), 0);
    chk("step_y_held", 32'(y), 32'(m_lfsr));
    tick();
    chk("resp_valid", 32'(rsp_valid), 1);
    chk("resp_data", 32'(rsp_data), 32'(exp));
    chk("resp_id", 32'(rsp_id), 32'(id));
    chk("resp_y", 32'(y), 32'(exp));
    for (int w = 0; w < dly; w++) begin
      tick();
      chk("wait_valid", 32'(rsp_valid), 1);
      chk("wait_data", 32'(rsp_data), 32'(exp));
      chk("wait_id", 32'(rsp_id), 32'(id));
      chk("wait_y", 32'(y), 32'(exp));
      chk("wait_no_ack", 32'(ack), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ack", 32'(ack), 32'(oh));
    tick();
    if (!hold) req = 4'b0000;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_ack", 32'(ack), 0);
    m_ptr  = id;
    m_lfsr = exp;
  endtask

  task automatic do_seed(input logic [15:0] val);
    seed_valid = 1'b1;
    seed_data  = val;
    tick();
    chk("seed_ack_hi", 32'(seed_ack), 1);
    chk("seed_y_held", 32'(y), 32'(m_lfsr));
    tick();
    seed_valid = 1'b0;
    m_lfsr = (val == 16'h0000) ? 16'hACE1 : val;
    chk("seed_ack_lo", 32'(seed_ack), 0);
    chk("seed_y", 32'(y), 32'(m_lfsr));
  endtask

  initial begin
    reset_n = 1'b0; req = '0; rsp_ready = 1'b0; seed_valid = 1'b0; seed_data = '0;
    m_lfsr = 16'hACE1; m_ptr = 3;
    #12;
    chk("rst_y", 32'(y), 32'hACE1);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_seed_ack", 32'(seed_ack), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_data", 32'(rsp_data), 0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Single requester 2: first word from ACE1 is 59C3.
    do_txn(4'b0100, 0, 1'b0);
    chk("first_word", 32'(m_lfsr), 32'h59C3);

    // Reset again so the all-request rotation starts from pointer 3.
    reset_n = 1'b0; #1; reset_n = 1'b1;
    m_lfsr = 16'hACE1; m_ptr = 3;
    tick();
    for (int g = 0; g < 5; g++) begin
      do_txn(4'b1111, 0, 1'b1);
      chk("rr_order", 32'(m_ptr), 32'(g % 4));
    end
    req = 4'b0000;
    tick();
    chk("rr_idle_y", 32'(y), 32'(m_lfsr));

    // Back-pressure for 5 cycles.
    do_txn(4'b0100, 5, 1'b0);

    // Zero seed substitutes the reset seed; nonzero seed loads as given.
    do_seed(16'h0000);
    do_seed(16'h1234);
    do_txn(4'b0010, 1, 1'b0);

    // Seed arriving during RESP waits, then wins over a pending request.
    req = 4'b0001;
    tick(); tick();
    chk("pend_valid", 32'(rsp_valid), 1);
    seed_valid = 1'b1; seed_data = 16'hBEEF;
    tick();
    chk("pend_no_seed_ack", 32'(seed_ack), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req = 4'b1000;
    m_lfsr = model_step(m_lfsr); m_ptr = 0;
    chk("pend_idle_seed_ack", 32'(seed_ack), 0);
    tick();
    chk("pend_seed_ack", 32'(seed_ack), 1);
    tick();
    seed_valid = 1'b0; req = 4'b0000;
    chk("pend_seed_y", 32'(y), 32'hBEEF);
    m_lfsr = 16'hBEEF;
    tick();

    // Randomized transactions with occasional seeds.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 4) == 0)
        do_seed(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during RESP discards the response asynchronously.
    req = 4'b0100;
    tick(); tick();
    chk("mid_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_y", 32'(y), 32'hACE1);
    chk("arst_ack", 32'(ack), 0);
    req = 4'b0000;
    @(negedge clk); reset_n = 1'b1;
    m_lfsr = 16'hACE1; m_ptr = 3;
    tick();
    do_txn(4'b1111, 0, 1'b0);
    chk("arst_first_grant", 32'(m_ptr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
